// File: rtl/ripple_carry_add.sv
// 4-bit ripple-carry adder built from four chained full-adder cells.
// The sum bits and every intermediate carry are registered on a single clock.
module ripple_carry_add (
  input  logic clk,
  input  logic rst,
  input  logic A0,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic B0,
  input  logic B1,
  input  logic B2,
  input  logic B3,
  input  logic Cin,
  output logic S0,
  output logic S1,
  output logic S2,
  output logic S3,
  output logic C1,
  output logic C2,
  output logic C3,
  output logic C4
);

  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] sum;
  logic [4:0] carry;
  logic [3:0] sum_q;
  logic [4:1] carry_q;

  assign a = {A3, A2, A1, A0};
  assign b = {B3, B2, B1, B0};

  // Each cell consumes the carry produced by the cell below it, so the
  // loop order matters: bit i must be evaluated before bit i+1.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    sum      = '0;
    carry    = '0;
    carry[0] = Cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so all flops update
    // together from values sampled at the same edge.
    if (rst) begin
      sum_q   <= '0;
      carry_q <= '0;
    end else begin
      sum_q   <= sum;
      carry_q <= carry[4:1];
    end
  end

  assign {S3, S2, S1, S0} = sum_q;
  assign {C4, C3, C2, C1} = carry_q;

endmodule

// File: tb/tb_ripple_carry_add.sv
// Scoreboard bench for ripple_carry_add: the driver queues the expected
// registered result, and a monitor pops and compares it one cycle later.
module tb_ripple_carry_add;

  typedef struct {
    string      name;
    logic [7:0] exp;   // {C4,C3,C2,C1,S3,S2,S1,S0}
  } entry_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  wire  [3:0] s;
  wire  [4:1] c;

  entry_t sb[$];
  int     total  = 0;
  int     passed = 0;

  ripple_carry_add dut (
    .clk (clk),
    .rst (rst),
    .A0  (a[0]),
    .A1  (a[1]),
    .A2  (a[2]),
    .A3  (a[3]),
    .B0  (b[0]),
    .B1  (b[1]),
    .B2  (b[2]),
    .B3  (b[3]),
    .Cin (cin),
    .S0  (s[0]),
    .S1  (s[1]),
    .S2  (s[2]),
    .S3  (s[3]),
    .C1  (c[1]),
    .C2  (c[2]),
    .C3  (c[3]),
    .C4  (c[4])
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Golden model: carry into bit i+1 is the overflow of adding the low
  // i+1 bits of each operand plus Cin.
  function automatic logic [7:0] golden(input logic [3:0] av, input logic [3:0] bv, input logic ci);
    logic [4:0] full;
    logic [4:0] part;
    logic [4:0] mask;
    logic [4:1] cv;
    full = {1'b0, av} + {1'b0, bv} + {4'b0, ci};
    for (int i = 0; i < 4; i++) begin
      mask      = 5'((1 << (i + 1)) - 1);
      part      = ({1'b0, av} & mask) + ({1'b0, bv} & mask) + {4'b0, ci};
      cv[i + 1] = part[i + 1];
    end
    return {cv, full[3:0]};
  endfunction

  task automatic apply(input logic r, input logic [3:0] av, input logic [3:0] bv,
                       input logic ci, input logic [7:0] exp, input string name);
    entry_t e;
    @(negedge clk);
    rst = r;
    a   = av;
    b   = bv;
    cin = ci;
    e.name = name;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // Monitor: every edge produces a result; compare it against the oldest
  // queued expectation.
  initial begin
    entry_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name, {24'b0, c, s}, {24'b0, e.exp});
      end
    end
  end

  initial begin
    rst = 1'b1;
    a   = 4'b1111;
    b   = 4'b1111;
    cin = 1'b1;

    apply(1'b1, 4'b1111, 4'b1111, 1'b1, 8'b0000_0000, "reset_edge_1");
    apply(1'b1, 4'b1111, 4'b1111, 1'b1, 8'b0000_0000, "reset_edge_2");
    apply(1'b0, 4'b0000, 4'b0000, 1'b0, 8'b0000_0000, "zero_plus_zero");
    apply(1'b0, 4'b1111, 4'b0001, 1'b0, 8'b1111_0000, "overflow_wrap");
    apply(1'b0, 4'b0101, 4'b0011, 1'b0, 8'b0111_1000, "five_plus_three");
    apply(1'b0, 4'b1111, 4'b1111, 1'b1, 8'b1111_1111, "all_ones_cin");
    apply(1'b0, 4'b0110, 4'b1001, 1'b0, 8'b0000_1111, "no_carry_fill");
    apply(1'b0, 4'b0110, 4'b1001, 1'b1, 8'b1111_0000, "full_propagate");

    for (int k = 0; k < 512; k++) begin
      logic [3:0] av;
      logic [3:0] bv;
      logic       ci;
      av = 4'(k >> 5);
      bv = 4'(k >> 1);
      ci = k[0];
      if (k == 256) begin
        apply(1'b1, av, bv, ci, 8'b0000_0000, "mid_reset");
      end
      apply(1'b0, av, bv, ci, golden(av, bv, ci), $sformatf("exh_%0d", k));
    end

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) check("scoreboard_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
